// File: rtl/data_memory_access.sv
// data_memory_access: MEM-stage handshake master for an SRAM-like data port.
// Define DM_ALIGN_CHECK_EN to raise adel/ades on misaligned word/half accesses.
`ifndef memWidth4
`define memWidth4 2'd2
`endif
`ifndef memWidth2
`define memWidth2 2'd1
`endif
`ifndef memWidth1
`define memWidth1 2'd0
`endif
module data_memory_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  widthCtrl,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        flush,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] rdata_q,
  output logic        rdata_valid
);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DONE, DRAIN} state_t;
  state_t      state_q, state_d;
  logic        wr_q;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        is_word, is_half, misaligned, start, capture;
  assign is_word = widthCtrl == `memWidth4;
  assign is_half = widthCtrl == `memWidth2;
`ifdef DM_ALIGN_CHECK_EN
  assign misaligned = (is_word && address[1:0] != 2'b00) || (is_half && address[0]);
`else
  assign misaligned = 1'b0;
`endif
  assign start = state_q == IDLE && req_valid && !flush && !misaligned;
  // A flushed access still has to see its data_ok before the port is free again.
  assign capture = !flush && !wr_q && data_sram_data_ok &&
                   ((state_q == ADDR && data_sram_addr_ok) || state_q == WAIT);
  always_comb begin
    size_d  = is_word ? 2'd2 : is_half ? 2'd1 : 2'd0;
    wdata_d = is_word ? writeData : is_half ? {2{writeData[15:0]}} : {4{writeData[7:0]}};
    wstrb_d = !req_write ? 4'b0000 : is_word ? 4'b1111 :
              is_half ? (address[1] ? 4'b1100 : 4'b0011) : 4'b0001 << address[1:0];
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ADDR : IDLE;
      ADDR:    state_d = data_sram_addr_ok
                         ? (data_sram_data_ok ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT))
                         : (flush ? IDLE : ADDR);
      WAIT:    state_d = data_sram_data_ok ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT);
      DONE:    state_d = IDLE;
      DRAIN:   state_d = data_sram_data_ok ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        wr_q    <= req_write;
        size_q  <= size_d;
        addr_q  <= address;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
      end
      if (capture) rdata_q <= data_sram_rdata;
    end
  end
  assign stall           = !reset && (start || state_q == ADDR || state_q == WAIT);
  assign adel            = !reset && state_q == IDLE && req_valid && !flush && misaligned && !req_write;
  assign ades            = !reset && state_q == IDLE && req_valid && !flush && misaligned && req_write;
  assign data_sram_req   = !reset && state_q == ADDR;
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;
  assign data_sram_wstrb = reset ? 4'b0000 : wstrb_q;
  assign rdata_valid     = !reset && state_q == DONE && !wr_q;
endmodule

// File: tb/tb_data_memory_access.sv
// tb_data_memory_access: vector table, directed corner sequences and random
// transactions checked against an arithmetic model of the data port.
module tb_data_memory_access;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, flush = 1'b0;
  logic [1:0]  widthCtrl = 2'd0;
  logic [31:0] address = 32'd0, writeData = 32'd0;
  logic        stall, adel, ades, data_sram_req, data_sram_wr, rdata_valid;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, rdata_q;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = 32'd0;
  int          total = 0, bad = 0;
  logic [31:0] exp_rq = 32'd0;

  data_memory_access dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .widthCtrl(widthCtrl), .address(address), .writeData(writeData), .flush(flush),
    .stall(stall), .adel(adel), .ades(ades), .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .rdata_q(rdata_q), .rdata_valid(rdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  w;
    logic [31:0] a;
    bit          wr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  sz;
    logic [3:0]  st;
    logic [31:0] d;
  } vec_t;
  vec_t tbl[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [1:0] w, input logic [31:0] a, input bit wr,
                                input logic [31:0] wd, output logic [1:0] sz,
                                output logic [3:0] st, output logic [31:0] d);
    int n, lane;
    n    = (w == 2'd2) ? 4 : (w == 2'd1) ? 2 : 1;
    lane = int'(a[1:0]) & ~(n - 1);
    sz   = 2'(n >> 1);
    st   = wr ? 4'(((1 << n) - 1) << lane) : 4'd0;
    d    = (n == 4) ? wd : (n == 2) ? (wd & 32'hFFFF) * 32'h00010001 : (wd & 32'hFF) * 32'h01010101;
  endfunction

  task automatic run_txn(input logic [1:0] w, input logic [31:0] a, input bit wr,
                         input logic [31:0] wd, input int adly, input int ddly,
                         input logic [31:0] rd, input logic [1:0] esz,
                         input logic [3:0] est, input logic [31:0] ed);
    req_valid = 1'b1; req_write = wr; widthCtrl = w; address = a; writeData = wd;
    flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    #2;
    chk("idle_stall", stall, 1);
    chk("idle_req", data_sram_req, 0);
    chk("idle_adel", adel, 0);
    chk("idle_ades", ades, 0);
    tick;
    address = $urandom; writeData = $urandom;
    for (int k = 0; k <= adly; k++) begin
      data_sram_addr_ok = (k == adly);
      data_sram_data_ok = (k == adly) && (ddly == 0);
      data_sram_rdata   = data_sram_data_ok ? rd : $urandom;
      #2;
      chk("addr_req", data_sram_req, 1);
      chk("addr_stall", stall, 1);
      chk("addr_wr", data_sram_wr, wr);
      chk("addr_size", data_sram_size, esz);
      chk("addr_addr", data_sram_addr, a);
      chk("addr_wstrb", data_sram_wstrb, est);
      chk("addr_wdata", data_sram_wdata, ed);
      tick;
    end
    for (int j = 1; j <= ddly; j++) begin
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = (j == ddly);
      data_sram_rdata   = data_sram_data_ok ? rd : $urandom;
      #2;
      chk("wait_req", data_sram_req, 0);
      chk("wait_stall", stall, 1);
      chk("wait_rvalid", rdata_valid, 0);
      tick;
    end
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
    if (!wr) exp_rq = rd;
    #2;
    chk("done_stall", stall, 0);
    chk("done_rvalid", rdata_valid, !wr);
    chk("done_rdata", rdata_q, exp_rq);
    tick;
    req_valid = 1'b0;
    #2;
    chk("after_req", data_sram_req, 0);
    chk("after_stall", stall, 0);
    chk("after_rvalid", rdata_valid, 0);
    chk("after_rdata", rdata_q, exp_rq);
  endtask

  initial begin
    logic [1:0]  w, sz;
    logic [3:0]  st;
    logic [31:0] a, wd, d;
    bit          wr;
    tbl[0] = '{2'd2, 32'h200, 1'b1, 32'h12345678, 32'h0, 2'd2, 4'b1111, 32'h12345678};
    tbl[1] = '{2'd1, 32'h202, 1'b1, 32'hABCD1234, 32'h0, 2'd1, 4'b1100, 32'h12341234};
    tbl[2] = '{2'd1, 32'h200, 1'b1, 32'h0000BEEF, 32'h0, 2'd1, 4'b0011, 32'hBEEFBEEF};
    tbl[3] = '{2'd0, 32'h101, 1'b1, 32'h00000077, 32'h0, 2'd0, 4'b0010, 32'h77777777};
    tbl[4] = '{2'd0, 32'h103, 1'b1, 32'h000000A5, 32'h0, 2'd0, 4'b1000, 32'hA5A5A5A5};
    tbl[5] = '{2'd2, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF, 2'd2, 4'b0000, 32'h0};
    tbl[6] = '{2'd0, 32'h102, 1'b0, 32'h0, 32'hCAFEF00D, 2'd0, 4'b0000, 32'h0};

    // Reset with a misaligned store request pending: everything stays quiet.
    req_valid = 1'b1; req_write = 1'b1; widthCtrl = 2'd2; address = 32'h101;
    tick; tick;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_req", data_sram_req, 0);
    chk("rst_adel", adel, 0);
    chk("rst_ades", ades, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_wstrb", data_sram_wstrb, 0);
    chk("rst_rdata", rdata_q, 0);
    reset = 1'b0; req_valid = 1'b0;
    tick;

    foreach (tbl[i])
      run_txn(tbl[i].w, tbl[i].a, tbl[i].wr, tbl[i].wd, 0, 0, tbl[i].rd,
              tbl[i].sz, tbl[i].st, tbl[i].d);

    // Word load, immediate response.
    run_txn(2'd2, 32'h100, 1'b0, 32'h0, 0, 0, 32'hDEADBEEF, 2'd2, 4'b0000, 32'h0);
    // Byte store with addr_ok held off three cycles.
    run_txn(2'd0, 32'h103, 1'b1, 32'h000000A5, 3, 0, 32'h0, 2'd0, 4'b1000, 32'hA5A5A5A5);
    // Half load with data_ok five cycles after addr_ok.
    run_txn(2'd1, 32'h102, 1'b0, 32'h0, 0, 5, 32'h5A5A1234, 2'd1, 4'b0000, 32'h0);

    // data_ok while idle must not touch rdata_q.
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0BAD0;
    tick;
    data_sram_data_ok = 1'b0;
    #2;
    chk("idle_dok_rdata", rdata_q, exp_rq);
    chk("idle_dok_rvalid", rdata_valid, 0);

    // Flush in WAIT, response arrives two cycles later and is dropped.
    req_valid = 1'b1; req_write = 1'b0; widthCtrl = 2'd2; address = 32'h300;
    tick;
    data_sram_addr_ok = 1'b1;
    tick;
    data_sram_addr_ok = 1'b0; flush = 1'b1;
    #2;
    chk("flush_wait_stall", stall, 1);
    tick;
    flush = 1'b0; req_valid = 1'b0;
    #2;
    chk("drain_stall", stall, 0);
    chk("drain_rvalid", rdata_valid, 0);
    tick;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111;
    #2;
    chk("drain2_stall", stall, 0);
    chk("drain2_rvalid", rdata_valid, 0);
    tick;
    data_sram_data_ok = 1'b0;
    #2;
    chk("flush_rdata", rdata_q, exp_rq);
    chk("flush_rvalid", rdata_valid, 0);
    run_txn(2'd2, 32'h304, 1'b0, 32'h0, 1, 1, 32'h0F0F0F0F, 2'd2, 4'b0000, 32'h0);

    // Flush in ADDR before acceptance abandons the request.
    req_valid = 1'b1; req_write = 1'b1; widthCtrl = 2'd2; address = 32'h500;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0; req_valid = 1'b0;
    #2;
    chk("aflush_req", data_sram_req, 0);
    chk("aflush_stall", stall, 0);
    tick;
    chk("aflush_req2", data_sram_req, 0);

    // Misaligned word load.
`ifdef DM_ALIGN_CHECK_EN
    req_valid = 1'b1; req_write = 1'b0; widthCtrl = 2'd2; address = 32'h102;
    #2;
    chk("mis_adel", adel, 1);
    chk("mis_ades", ades, 0);
    chk("mis_stall", stall, 0);
    tick;
    req_valid = 1'b0;
    #2;
    chk("mis_req", data_sram_req, 0);
    chk("mis_adel_off", adel, 0);
    req_valid = 1'b1; req_write = 1'b1; widthCtrl = 2'd1; address = 32'h101;
    #2;
    chk("mis_st_ades", ades, 1);
    chk("mis_st_adel", adel, 0);
    tick;
    req_valid = 1'b0;
    #2;
    chk("mis_st_req", data_sram_req, 0);
`else
    run_txn(2'd2, 32'h102, 1'b0, 32'h0, 0, 0, 32'h0BADF00D, 2'd2, 4'b0000, 32'h0);
`endif

    // Reset while in ADDR.
    req_valid = 1'b1; req_write = 1'b1; widthCtrl = 2'd2; address = 32'h400; writeData = 32'h1;
    tick;
    reset = 1'b1;
    #2;
    chk("rstaddr_req", data_sram_req, 0);
    chk("rstaddr_stall", stall, 0);
    tick;
    reset = 1'b0; req_valid = 1'b0; exp_rq = 32'd0;
    #2;
    chk("rstaddr_req2", data_sram_req, 0);
    chk("rstaddr_stall2", stall, 0);
    chk("rstaddr_rdata", rdata_q, 0);
    chk("rstaddr_wstrb", data_sram_wstrb, 0);
    tick;
    chk("rstaddr_req3", data_sram_req, 0);

    // Random transactions against the model.
    for (int i = 0; i < 30; i++) begin
      w  = 2'($urandom_range(0, 2));
      a  = $urandom;
      wr = 1'($urandom);
      wd = $urandom;
`ifdef DM_ALIGN_CHECK_EN
      a = (w == 2'd2) ? {a[31:2], 2'b00} : (w == 2'd1) ? {a[31:1], 1'b0} : a;
`endif
      model(w, a, wr, wd, sz, st, d);
      run_txn(w, a, wr, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, sz, st, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_memory_access.md
DATA_MEMORY_ACCESS -- requirements
Module: data_memory_access

Interface
REQ-001 No parameters; access widths SHALL use the `memWidth4/`memWidth2/`memWidth1 encodings from constants.v.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  MEM-stage instruction performs a memory access.
REQ-005 req_write  in  1  1=store, 0=load.
REQ-006 widthCtrl  in  2  access width.
REQ-007 address  in  32  byte address.
REQ-008 writeData  in  32  store data, right-aligned.
REQ-009 flush  in  1  discard the current access (exception/eret).
REQ-010 stall  out  1  hold the pipeline.
REQ-011 adel / ades  out  1 each  load / store address-error exception.
REQ-012 data_sram_req, data_sram_wr  out  1 each  request strobe; write flag.
REQ-013 data_sram_size  out  2  0=byte, 1=half, 2=word.
REQ-014 data_sram_addr, data_sram_wdata  out  32 each  address; replicated write data.
REQ-015 data_sram_wstrb  out  4  byte enables.
REQ-016 data_sram_addr_ok, data_sram_data_ok  in  1 each  request accepted; response done.
REQ-017 data_sram_rdata  in  32  raw read word.
REQ-018 rdata_q  out  32  captured read word, fed to the downstream load extractor.
REQ-019 rdata_valid  out  1  rdata_q valid for the current instruction.

Function
REQ-020 FSM states IDLE, ADDR, WAIT, DONE, DRAIN; request fields SHALL be registered on IDLE->ADDR and held until return to IDLE.
REQ-021 IDLE: req_valid && !flush && !misaligned -> ADDR; stall=1 combinationally in that cycle.
REQ-022 ADDR: data_sram_req=1 with held fields; addr_ok && data_ok -> DONE; addr_ok only -> WAIT; flush && !addr_ok -> IDLE, no request issued.
REQ-023 WAIT: data_ok -> DONE; flush -> DRAIN.
REQ-024 DRAIN: stall=0, rdata_valid=0; data_ok -> IDLE with data discarded.
REQ-025 DONE: stall=0, rdata_valid=1 (loads only), exactly one cycle, then IDLE; req_valid in DONE SHALL NOT start a new access.
REQ-026 stall SHALL be 1 in ADDR and WAIT, and 0 in DONE and DRAIN.
REQ-027 rdata_q SHALL load data_sram_rdata on the data_ok cycle of a load and otherwise hold.
REQ-028 wstrb: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0]; reads 0000.
REQ-029 wdata: word as is; half {2{writeData[15:0]}}; byte {4{writeData[7:0]}}.
REQ-030 data_sram_addr SHALL carry the full byte address; the downstream stage uses its low bits for lane selection.
REQ-031 data_ok received outside WAIT/DRAIN (or outside ADDR with addr_ok) SHALL be ignored.

Reset
REQ-032 reset SHALL force IDLE; stall, adel, ades, data_sram_req, rdata_valid, wstrb SHALL be 0 and rdata_q SHALL be 0, regardless of state; the memory side is reset concurrently.

Configuration
REQ-033 With DM_ALIGN_CHECK_EN defined: misaligned = (word && addr[1:0]!=0) || (half && addr[0]); in IDLE, req_valid && misaligned SHALL pulse adel (load) or ades (store) combinationally, stall=0, no SRAM request.
REQ-034 Without DM_ALIGN_CHECK_EN: adel=ades=0 always, misaligned treated as 0, and the request is issued with the address unmodified.

Verification
REQ-035 Word load addr 0x100, addr_ok and data_ok both 1 cycle later, rdata 0xDEADBEEF -> req 1 cycle, stall 2 cycles, rdata_valid=1 with rdata_q=0xDEADBEEF, then IDLE.
REQ-036 Byte store addr 0x103, writeData 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5, size 0; addr_ok delayed 3 cycles -> req held 4 cycles with constant fields.
REQ-037 Half load addr 0x102, data_ok 5 cycles after addr_ok -> stall stays 1 throughout, rdata_valid on the cycle after data_ok.
REQ-038 flush in WAIT, data_ok 2 cycles later -> stall drops immediately, rdata_valid never set, rdata_q unchanged, next access accepted after data_ok.
REQ-039 DM_ALIGN_CHECK_EN, word load addr 0x102 -> adel=1 for 1 cycle, no data_sram_req; without the macro -> normal request at 0x102.
REQ-040 reset asserted in ADDR -> next cycle IDLE, data_sram_req=0, all outputs at reset values.
